scan_enb_decoder: RTL
=====================

// Module: scan_enb_decoder
// PURPOSE
//  Parametrised, registered N-to-2^N enabled decoder with one-hot output.
//  - Decode mode: selected output asserted with 1-cycle latency.
//  - Scan mode: output walks z[0..M-1] cyclically; drives digit strobes and row selects.
//  - Sits between control FSMs and banks of enables.
// PARAMETERS
//  N        3  select width
//  M        2**N  output count; localparam, not overridable
//  DWELL_W  8  dwell field width; used only with SCAN_DWELL_EN
// PORTS
//  clock   in   1        system clock; all state updates on rising edge
//  reset   in   1        synchronous, active-high reset
//  e       in   1        enable: 0 forces z to zero; scan index freezes
//  mode    in   1        0 = decode, 1 = scan; sampled only in IDLE
//  x       in   N        decode select / scan start index
//  start   in   1        scan start pulse (IDLE or RUN)
//  stop    in   1        scan stop pulse
//  dwell   in   DWELL_W  cycles-per-index minus 1; present only with SCAN_DWELL_EN
//  z       out  M        one-hot output, or zero
//  idx     out  N        index currently driven (binary)
//  wrap    out  1        1-cycle pulse when scan index rolls M-1 -> 0
//  busy    out  1        1 while state == RUN
// BEHAVIOUR
//  Reset: z=0, idx=0, wrap=0, busy=0, state=IDLE, dwell counter=0.
//    Applies on any cycle, including mid-scan.
//  FSM states: IDLE, RUN.
//  IDLE, mode=0 (decode):
//    - Each cycle: idx<=x; z<= e ? (1<<x) : 0.
//    - Latency 1 cycle; start/stop ignored.
//  IDLE, mode=1:
//    - No start: z<=0, idx holds.
//    - start=1 & stop=0: -> RUN; idx<=x; z<= e ? (1<<x) : 0.
//  RUN:
//    - Tick: advance idx<=(idx+1) mod M; z<= e ? (1<<idx_next) : 0.
//    - Rollover M-1 -> 0: wrap=1 for the same cycle as the new idx; otherwise wrap=0.
//    - e=0: idx and dwell counter hold, z=0, no wrap. Resume on e=1 from the held idx.
//    - stop=1: -> IDLE next edge; z<=0; idx holds; wrap=0. stop beats start in the same cycle.
//    - start=1 (without stop): restart at idx<=x; dwell counter cleared; no wrap.
//    - mode is ignored in RUN.
//  Outputs are registered; z is always one-hot or zero, never multi-hot.
// CONFIGURATION
//  SCAN_DWELL_EN defined:
//    - dwell port exists, latched on start.
//    - Each index held dwell+1 cycles (dwell=0 means advance every cycle).
//    - Tick = dwell counter reaching the latched value, then counter resets to 0.
//  SCAN_DWELL_EN undefined:
//    - No dwell port; tick every RUN cycle with e=1.
// STRUCTURE
//  Package scan_dec_pkg:
//    - typedef enum {IDLE, RUN} scan_state_t
//    - function onehot(sel) returning M-bit 1<<sel
//  Sub-module dwell_counter (DWELL_W):
//    - Inputs clock, reset, clr, en, lim; output tick.
//    - Instantiated only under SCAN_DWELL_EN.
// TESTING (N=3; dwell tests with SCAN_DWELL_EN)
//  1. Decode: mode=0, e=1, x=5 -> next cycle z=8'b0010_0000, idx=5; e=0 -> next cycle z=0.
//  2. Scan: mode=1, start with x=6 -> z: 0x40, 0x80, 0x01 (wrap=1 on the 0x01 cycle), 0x02 ...
//  3. Freeze: e=0 for 3 cycles while idx=2 -> z=0, idx stays 2; e=1 -> z=0x04, then 0x08.
//  4. Priority: start and stop in the same RUN cycle -> IDLE, z=0, busy=0.
//     Restart while RUN at idx=4 with x=1 -> z=0x02, no wrap.
//  5. Dwell: dwell=2, start x=7 -> z=0x80 for 3 cycles, then 0x01 (wrap=1) for 3 cycles.
//  6. Reset mid-scan at idx=3 -> next cycle z=0, idx=0, busy=0, wrap=0.
//     Then start x=0 -> z=0x01.

Source files
------------

// File: rtl/scan_enb_decoder_pkg.sv
// Shared types and helpers for the enabled one-hot decoder.
// Selects wider than SEL_W_MAX bits are not supported by onehot().
package scan_enb_decoder_pkg;

   localparam int unsigned SEL_W_MAX = 8;
   localparam int unsigned M_MAX     = 2 ** SEL_W_MAX;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } scan_state_t;

   // Callers cast the result down to their own output count.
   function automatic logic [M_MAX-1:0] onehot(input logic [SEL_W_MAX-1:0] sel);
      logic [M_MAX-1:0] v;
      v      = '0;
      v[sel] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/scan_enb_decoder_dwell_counter.sv
// Dwell counter: counts enabled cycles up to a limit, pulses tick on the
// limit cycle and wraps to zero. Only built when SCAN_DWELL_EN is defined.
module scan_enb_decoder_dwell_counter #(
   parameter int unsigned DWELL_W = 8
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic               i_clr,
   input  logic               i_en,
   input  logic [DWELL_W-1:0] i_lim,
   output logic               o_tick
);

   logic [DWELL_W-1:0] r_cnt;
   logic               w_hit;

   assign w_hit  = (r_cnt == i_lim);
   assign o_tick = i_en & w_hit;

   // Count enabled cycles; clear on reset, on request, or after reaching the limit.
   always_ff @(posedge i_clock) begin
      if (i_reset || i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= w_hit ? '0 : r_cnt + DWELL_W'(1);
      end
   end

endmodule

// File: rtl/scan_enb_decoder.sv
// Registered N-to-2^N enabled decoder with a cyclic scan mode.
// Define SCAN_DWELL_EN to add the dwell port and hold each scan index
// for dwell+1 cycles; without it the scan advances every enabled cycle.
module scan_enb_decoder
   import scan_enb_decoder_pkg::*;
#(
   parameter int unsigned N = 3
`ifdef SCAN_DWELL_EN
   ,
   parameter int unsigned DWELL_W = 8
`endif
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic               i_e,
   input  logic               i_mode,
   input  logic [N-1:0]       i_x,
   input  logic               i_start,
   input  logic               i_stop,
`ifdef SCAN_DWELL_EN
   input  logic [DWELL_W-1:0] i_dwell,
`endif
   output logic [2**N-1:0]    o_z,
   output logic [N-1:0]       o_idx,
   output logic               o_wrap,
   output logic               o_busy
);

   localparam int unsigned M = 2 ** N;

   scan_state_t r_state;
   logic [M-1:0] r_z;
   logic [N-1:0] r_idx;
   logic         r_wrap;

   logic [N-1:0] w_idx_nxt;
   logic [M-1:0] w_z_x;
   logic [M-1:0] w_z_idx;
   logic [M-1:0] w_z_nxt;
   logic         w_go;
   logic         w_load;
   logic         w_adv;
   logic         w_tick;

   assign w_idx_nxt = r_idx + N'(1);
   assign w_z_x     = i_e ? M'(onehot(SEL_W_MAX'(i_x))) : '0;
   assign w_z_idx   = M'(onehot(SEL_W_MAX'(r_idx)));
   assign w_z_nxt   = M'(onehot(SEL_W_MAX'(w_idx_nxt)));
   assign w_go      = i_start & ~i_stop;
   assign w_load    = w_go & ((r_state == RUN) | i_mode);
   // Advance only once the current index has actually been shown (z non-zero),
   // so resuming after e=0 first re-displays the held index.
   assign w_adv     = (r_state == RUN) & i_e & ~i_start & ~i_stop & (|r_z);

`ifdef SCAN_DWELL_EN
   logic [DWELL_W-1:0] r_lim;

   // Latch the dwell limit whenever a scan (re)starts.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_lim <= '0;
      end else if (w_load) begin
         r_lim <= i_dwell;
      end
   end

   scan_enb_decoder_dwell_counter #(
      .DWELL_W (DWELL_W)
   ) u_dwell (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .i_clr   (w_load),
      .i_en    (w_adv),
      .i_lim   (r_lim),
      .o_tick  (w_tick)
   );
`else
   assign w_tick = w_adv;
`endif

   // Scan FSM with registered outputs; stop beats start, start beats advance.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state <= IDLE;
         r_z     <= '0;
         r_idx   <= '0;
         r_wrap  <= 1'b0;
      end else begin
         r_wrap <= 1'b0;
         case (r_state)
            IDLE: begin
               if (!i_mode) begin
                  r_idx <= i_x;
                  r_z   <= w_z_x;
               end else if (w_go) begin
                  r_state <= RUN;
                  r_idx   <= i_x;
                  r_z     <= w_z_x;
               end else begin
                  r_z <= '0;
               end
            end
            RUN: begin
               if (i_stop) begin
                  r_state <= IDLE;
                  r_z     <= '0;
               end else if (i_start) begin
                  r_idx <= i_x;
                  r_z   <= w_z_x;
               end else if (!i_e) begin
                  r_z <= '0;
               end else if (w_tick) begin
                  r_idx  <= w_idx_nxt;
                  r_z    <= w_z_nxt;
                  r_wrap <= &r_idx;
               end else begin
                  r_z <= w_z_idx;
               end
            end
            default: begin
               r_state <= IDLE;
               r_z     <= '0;
            end
         endcase
      end
   end

   assign o_z    = r_z;
   assign o_idx  = r_idx;
   assign o_wrap = r_wrap;
   assign o_busy = (r_state == RUN);

endmodule
